// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared definitions for the 5-stage core pipeline control.
//   REG_W     - register address width (register 0 is hardwired zero)
//   state_e   - sequencing states of the hazard controller
//   NOP_INSTR - encoding loaded into a pipeline register to form a bubble
//               (all control bits zero)
package hazard_ctrl_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: event counter that stops at all-ones instead of wrapping.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears the count
//   inc    - count one event this cycle
//   count  - current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing for the 5-stage core. Resolves the hazards
// forwarding cannot: data-memory wait (full freeze), taken branch (flush the
// two younger instructions), load-use (one bubble), and HLT (drain then halt).
// Control outputs are combinational from state and current inputs so a stall
// takes effect in the cycle it is detected.
//   Inputs : if_id_rs/rt/uses_rt/halt (ID instruction), id_ex_memread/rd
//            (EX instruction), ex_branch_taken, ex_mem_memreq, dmem_ready
//   Outputs: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we,
//            mem_wb_we, halted, stall_cnt, flush_cnt (saturating),
//            dbg_state (current controller state)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             if_id_halt,
    input  logic             id_ex_memread,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mem_memreq,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_bubble,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [DW-1:0] r_drain;
    logic [DW-1:0] w_drain_nxt;
    logic          w_mem_wait;
    logic          w_load_use;
    logic          w_stall_inc;
    logic          w_flush_inc;

    assign w_mem_wait = ex_mem_memreq & ~dmem_ready;

    // Register 0 never carries a real dependency, so a load to r0 never stalls.
    assign w_load_use = id_ex_memread && (id_ex_rd != '0) &&
                        ((id_ex_rd == if_id_rs) ||
                         (if_id_uses_rt && (id_ex_rd == if_id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_nxt  = r_drain;
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_we    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_RUN: begin
                    if (!w_mem_wait) begin
                        pc_we     = 1'b1;
                        if_id_we  = 1'b1;
                        id_ex_we  = 1'b1;
                        ex_mem_we = 1'b1;
                        mem_wb_we = 1'b1;
                        if (ex_branch_taken) begin
                            if_id_flush  = 1'b1;
                            id_ex_bubble = 1'b1;
                        end else if (w_load_use) begin
                            pc_we        = 1'b0;
                            if_id_we     = 1'b0;
                            id_ex_bubble = 1'b1;
                        end else if (if_id_halt) begin
                            // HLT stays in ID; only the older instructions move on.
                            pc_we        = 1'b0;
                            if_id_we     = 1'b0;
                            id_ex_bubble = 1'b1;
                            w_state_nxt  = ST_DRAIN;
                            w_drain_nxt  = DW'(DRAIN_CYCLES - 1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // A branch cannot be in EX behind HLT, so it is ignored here.
                    if (!w_mem_wait) begin
                        id_ex_we     = 1'b1;
                        ex_mem_we    = 1'b1;
                        mem_wb_we    = 1'b1;
                        id_ex_bubble = 1'b1;
                        if (r_drain == '0) begin
                            w_state_nxt = ST_HALTED;
                        end else begin
                            w_drain_nxt = r_drain - DW'(1);
                        end
                    end
                end
                default: begin
                    // ST_HALTED: everything frozen until reset.
                end
            endcase
        end
    end

    assign w_stall_inc = rst_n && (r_state != ST_HALTED) && !pc_we;
    assign w_flush_inc = rst_n && (r_state == ST_RUN) && !w_mem_wait && ex_branch_taken;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

    assign halted    = (r_state == ST_HALTED);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// Inputs change 1 ns after a rising edge; Mealy controls are sampled on the
// falling edge and counters/state 1 ns after the next rising edge.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CNT_W = 16;

    // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble}
    localparam logic [6:0] C_NORMAL = 7'b11111_00;
    localparam logic [6:0] C_FREEZE = 7'b00000_00;
    localparam logic [6:0] C_BRANCH = 7'b11111_11;
    localparam logic [6:0] C_STALL  = 7'b00111_01;
    localparam logic [6:0] C_OFF    = 7'b00000_00;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] if_id_rs, if_id_rt, id_ex_rd;
    logic             if_id_uses_rt, if_id_halt, id_ex_memread;
    logic             ex_branch_taken, ex_mem_memreq, dmem_ready;
    logic             pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble;
    logic             ex_mem_we, mem_wb_we, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0]       dbg_state;
    logic [6:0]       ctl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble};

    hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .if_id_uses_rt   (if_id_uses_rt),
        .if_id_halt      (if_id_halt),
        .id_ex_memread   (id_ex_memread),
        .id_ex_rd        (id_ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_mem_memreq   (ex_mem_memreq),
        .dmem_ready      (dmem_ready),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .if_id_flush     (if_id_flush),
        .id_ex_we        (id_ex_we),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_we       (mem_wb_we),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .dbg_state       (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        if_id_rs        = '0;
        if_id_rt        = '0;
        id_ex_rd        = '0;
        if_id_uses_rt   = 1'b0;
        if_id_halt      = 1'b0;
        id_ex_memread   = 1'b0;
        ex_branch_taken = 1'b0;
        ex_mem_memreq   = 1'b0;
        dmem_ready      = 1'b1;
    endtask

    task automatic load(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs,
                        input logic [REG_W-1:0] rt, input logic uses_rt);
        id_ex_memread = 1'b1;
        id_ex_rd      = rd;
        if_id_rs      = rs;
        if_id_rt      = rt;
        if_id_uses_rt = uses_rt;
    endtask

    // One clock: check controls mid-cycle, then counters after the edge.
    task automatic cyc(input string tag, input logic [6:0] exp_ctl,
                       input int exp_stall, input int exp_flush);
        @(negedge clk);
        check({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
        @(posedge clk);
        #1;
        check({tag, ".stall"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, ".flush"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ".ctl"}, 32'(ctl), 32'(C_OFF));
        check({tag, ".halted"}, 32'(halted), 32'd0);
        check({tag, ".stall"}, 32'(stall_cnt), 32'd0);
        check({tag, ".flush"}, 32'(flush_cnt), 32'd0);
        check({tag, ".state"}, 32'(dbg_state), 32'(ST_RUN));
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #3;
        check("rst.ctl", 32'(ctl), 32'(C_OFF));
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.stall", 32'(stall_cnt), 32'd0);
        check("rst.flush", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc("idle", C_NORMAL, 0, 0);

        // Load-use on rs: one bubble, then normal flow.
        load(4'd3, 4'd3, 4'd7, 1'b1);
        cyc("lu_rs", C_STALL, 1, 0);
        idle_inputs();
        cyc("lu_after", C_NORMAL, 1, 0);

        // Exemptions: r0 destination, rt match without rt use.
        load(4'd0, 4'd0, 4'd0, 1'b1);
        cyc("lu_r0", C_NORMAL, 1, 0);
        load(4'd5, 4'd1, 4'd5, 1'b0);
        cyc("lu_rt_unused", C_NORMAL, 1, 0);
        load(4'd5, 4'd1, 4'd5, 1'b1);
        cyc("lu_rt", C_STALL, 2, 0);
        idle_inputs();

        // Branch wins over load-use.
        load(4'd3, 4'd3, 4'd0, 1'b0);
        ex_branch_taken = 1'b1;
        cyc("br_lu", C_BRANCH, 2, 1);
        idle_inputs();

        // Memory wait: four frozen cycles, then ready.
        ex_mem_memreq = 1'b1;
        dmem_ready    = 1'b0;
        for (int i = 0; i < 4; i++) cyc($sformatf("mw%0d", i), C_FREEZE, 3 + i, 1);
        dmem_ready = 1'b1;
        cyc("mw_ready", C_NORMAL, 6, 1);

        // Freeze beats a taken branch; no flush counted.
        dmem_ready      = 1'b0;
        ex_branch_taken = 1'b1;
        cyc("mw_br", C_FREEZE, 7, 1);
        idle_inputs();

        // Halt with one mem_wait mid-drain: halted after DRAIN_CYCLES+1 cycles.
        if_id_halt = 1'b1;
        cyc("hlt", C_STALL, 8, 1);
        check("hlt.state", 32'(dbg_state), 32'(ST_DRAIN));
        idle_inputs();
        cyc("drain1", C_STALL, 9, 1);
        check("drain1.halted", 32'(halted), 32'd0);
        ex_mem_memreq = 1'b1;
        dmem_ready    = 1'b0;
        cyc("drain_mw", C_FREEZE, 10, 1);
        idle_inputs();
        cyc("drain2", C_STALL, 11, 1);
        check("drain2.halted", 32'(halted), 32'd0);
        cyc("drain3", C_STALL, 12, 1);
        check("halted", 32'(halted), 32'd1);
        ex_mem_memreq   = 1'b1;
        dmem_ready      = 1'b0;
        ex_branch_taken = 1'b1;
        cyc("halted_hold", C_OFF, 12, 1);
        check("halted_hold.halted", 32'(halted), 32'd1);
        async_reset("rst_halted");

        // Reset in the middle of a drain.
        if_id_halt = 1'b1;
        cyc("hlt2", C_STALL, 1, 0);
        idle_inputs();
        async_reset("rst_drain");

        // Saturation of stall_cnt under a long memory wait.
        ex_mem_memreq = 1'b1;
        dmem_ready    = 1'b0;
        repeat ((1 << CNT_W) + 5) @(posedge clk);
        #1;
        check("sat.stall", 32'(stall_cnt), 32'hFFFF);
        cyc("sat_hold", C_FREEZE, 32'hFFFF, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It is the companion to the ALU operand forwarding unit and handles the hazards that forwarding cannot resolve:
- load-use stalls
- taken-branch flushes
- data-memory wait freezes
- halt drain

It drives the pipeline register write enables and bubble/flush controls, and keeps saturating stall/flush performance counters.

Parameters:
REG_W, 4, register address width (16 registers; register 0 is hardwired zero)
CNT_W, 16, width of performance counters
DRAIN_CYCLES, 3, cycles after HLT leaves ID until the pipeline is empty

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_id_rs  in  REG_W  source register 1 of the instruction in ID
if_id_rt  in  REG_W  source register 2 of the instruction in ID
if_id_uses_rt  in  1  ID instruction reads rt
if_id_halt  in  1  ID instruction is HLT
id_ex_memread  in  1  EX instruction is a load
id_ex_rd  in  REG_W  destination of the EX instruction
ex_branch_taken  in  1  branch resolved taken in EX
ex_mem_memreq  in  1  MEM stage issues a data-memory access
dmem_ready  in  1  data memory completes the access this cycle
pc_we  out  1  PC write enable
if_id_we  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_we  out  1  ID/EX write enable
id_ex_bubble  out  1  ID/EX loads a NOP (control bits zero)
ex_mem_we  out  1  EX/MEM write enable
mem_wb_we  out  1  MEM/WB write enable
halted  out  1  core halted
stall_cnt  out  CNT_W  cycles with pc_we=0 while not halted (saturating)
flush_cnt  out  CNT_W  taken-branch flushes (saturating)

Behaviour:
- States: RUN, DRAIN, HALTED. State register, drain counter and perf counters are sequential. Outputs are Mealy: combinational from state plus current inputs, so stalls act in the same cycle.
- Reset (rst_n=0, asynchronous): state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, halted=0. All *_we=0 and if_id_flush=id_ex_bubble=0 while rst_n is low.
- Default in RUN: all *_we=1, flush/bubble=0.
- Conditions evaluated each cycle:
  - mem_wait = ex_mem_memreq & ~dmem_ready
  - load_use = id_ex_memread & (id_ex_rd!=0) & ((id_ex_rd==if_id_rs) | (if_id_uses_rt & id_ex_rd==if_id_rt))
- Priority, highest first:
  1. mem_wait: all five *_we=0, flush/bubble=0. Full freeze; repeats every cycle until dmem_ready.
  2. ex_branch_taken: pc_we=1, if_id_flush=1, id_ex_bubble=1. Flushes the two younger instructions. Overrides load_use. flush_cnt increments.
  3. load_use: pc_we=0, if_id_we=0, id_ex_bubble=1. Exactly one bubble per load; the next cycle id_ex_memread is the bubble's 0.
  4. if_id_halt in RUN (no higher condition): pc_we=0, if_id_we=0, id_ex_bubble=1. HLT is not passed to EX; state->DRAIN with drain counter=DRAIN_CYCLES-1.
- DRAIN:
  - pc_we=0, if_id_we=0, id_ex_bubble=1; other stages advance.
  - mem_wait still freezes everything, and the counter holds.
  - Counter decrements each non-frozen cycle; at 0 with no mem_wait, state->HALTED.
- HALTED: halted=1, all *_we=0, counters hold. Exit only by reset.
- ex_branch_taken during DRAIN cannot occur (HLT is in ID only after older instructions); it is ignored.
- stall_cnt increments when pc_we=0 in RUN or DRAIN, including mem_wait.
- Both counters saturate at all-ones (no wrap).
- Reset mid-freeze or mid-drain returns to RUN immediately.

Decomposition:
- Shared core package holds REG_W, the state enum (RUN/DRAIN/HALTED) and the NOP/bubble constant used by pipeline registers.
- One sub-module: sat_counter (CNT_W, inc, count), instantiated twice.

Test Plan:
- Load-use: LW r3 in EX (id_ex_memread=1, id_ex_rd=3), ID reads rs=3 -> one cycle with pc_we=0, if_id_we=0, id_ex_bubble=1; stall_cnt 0->1; next cycle all *_we=1.
- Load-use exemptions:
  - id_ex_rd=0 with if_id_rs=0 -> no stall.
  - rt match with if_id_uses_rt=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 and load_use=1 in the same cycle -> pc_we=1, if_id_flush=1, id_ex_bubble=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait: ex_mem_memreq=1, dmem_ready=0 for 4 cycles, then 1 -> all *_we=0 for 4 cycles, stall_cnt=4, normal operation on the ready cycle.
- Halt: if_id_halt=1 -> DRAIN. Insert one mem_wait cycle mid-drain -> halted=1 after exactly DRAIN_CYCLES+1 cycles; all *_we=0 thereafter. Assert rst_n=0 asynchronously -> outputs/counters zero without waiting for a clock edge.
- Saturation: hold mem_wait for 2^CNT_W+5 cycles -> stall_cnt stays at all-ones.
